// File: rtl/kp_arb_pkg.sv
// rtl/kp_arb_pkg.sv - shared types and constants for the keypoint write arbiter
package kp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } kp_state_e;

  localparam int KP_COORD_W = 19;
  localparam int KP_WORD_W  = 20;

  localparam logic SCALE_1 = 1'b0;
  localparam logic SCALE_2 = 1'b1;

endpackage

// File: rtl/kp_fifo.sv
// rtl/kp_fifo.sv - small first-word-fall-through FIFO with flush; push accepted when full if popping
module kp_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypoint_write_arbiter.sv
// rtl/keypoint_write_arbiter.sv - round-robin merge of two keypoint streams into one tagged SRAM write port
module keypoint_write_arbiter import kp_arb_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_KP     = 4096,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  src_done,
  input  logic                  kp1_we,
  input  logic [KP_COORD_W-1:0] kp1_din,
  input  logic                  kp2_we,
  input  logic [KP_COORD_W-1:0] kp2_din,
  output logic                  kp_we,
  output logic [ADDR_W-1:0]     kp_addr,
  output logic [KP_WORD_W-1:0]  kp_din,
  output logic [ADDR_W:0]       kp1_count,
  output logic [ADDR_W:0]       kp2_count,
  output logic [ADDR_W:0]       total_count,
  output logic [1:0]            fifo_ovf,
  output logic                  mem_full,
  output logic                  done
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_KP);

  kp_state_e             state, state_nxt;
  logic                  clr, accept, arb_on, at_cap;
  logic                  push1, push2, pop1, pop2;
  logic                  f1_full, f2_full, f1_empty, f2_empty;
  logic [KP_COORD_W-1:0] f1_dout, f2_dout;
  logic                  last_s2;

  assign clr    = start && (state == ST_IDLE || state == ST_DONE);
  assign accept = (state == ST_RUN);
  assign arb_on = (state == ST_RUN) || (state == ST_DRAIN);
  assign push1  = kp1_we && accept;
  assign push2  = kp2_we && accept;
  // Scale 1 wins when alone or when scale 2 had the previous grant.
  assign pop1   = arb_on && !f1_empty && (f2_empty || last_s2);
  assign pop2   = arb_on && !f2_empty && !pop1;
  assign at_cap = (total_count == MAX_CNT);
  assign done   = (state == ST_DONE);

  kp_fifo #(.WIDTH(KP_COORD_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .flush(clr), .push(push1), .pop(pop1),
    .din(kp1_din), .dout(f1_dout), .full(f1_full), .empty(f1_empty)
  );

  kp_fifo #(.WIDTH(KP_COORD_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst_n(rst_n), .flush(clr), .push(push2), .pop(pop2),
    .din(kp2_din), .dout(f2_dout), .full(f2_full), .empty(f2_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
      ST_RUN:           if (src_done) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (f1_empty && f2_empty && !kp_we) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_we       <= 1'b0;
      kp_addr     <= '0;
      kp_din      <= '0;
      kp1_count   <= '0;
      kp2_count   <= '0;
      total_count <= '0;
      fifo_ovf    <= '0;
      mem_full    <= 1'b0;
      last_s2     <= 1'b1;
    end else if (clr) begin
      kp_we       <= 1'b0;
      kp_addr     <= '0;
      kp1_count   <= '0;
      kp2_count   <= '0;
      total_count <= '0;
      fifo_ovf    <= '0;
      mem_full    <= 1'b0;
    end else begin
      kp_we    <= 1'b0;
      fifo_ovf <= fifo_ovf | {push2 && f2_full && !pop2, push1 && f1_full && !pop1};
      if (pop1 || pop2) begin
        last_s2 <= pop2;
        // Once the SRAM is full, popped words are discarded so the drain still completes.
        if (at_cap) begin
          mem_full <= 1'b1;
        end else begin
          kp_we       <= 1'b1;
          kp_addr     <= total_count[ADDR_W-1:0];
          kp_din      <= pop2 ? {SCALE_2, f2_dout} : {SCALE_1, f1_dout};
          total_count <= total_count + (ADDR_W+1)'(1);
          if (pop2) kp2_count <= kp2_count + (ADDR_W+1)'(1);
          else      kp1_count <= kp1_count + (ADDR_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypoint_write_arbiter.sv
// tb/tb_keypoint_write_arbiter.sv - scoreboard bench for keypoint_write_arbiter
module tb_keypoint_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        c_start = 1'b0;
  logic        src_done = 1'b0;
  logic        kp1_we = 1'b0;
  logic        kp2_we = 1'b0;
  logic [18:0] kp1_din = '0;
  logic [18:0] kp2_din = '0;

  logic        kp_we, mem_full, done;
  logic [11:0] kp_addr;
  logic [19:0] kp_din;
  logic [12:0] kp1_count, kp2_count, total_count;
  logic [1:0]  fifo_ovf;

  logic        c_kp_we, c_mem_full, c_done;
  logic [2:0]  c_kp_addr;
  logic [19:0] c_kp_din;
  logic [3:0]  c_kp1_count, c_kp2_count, c_total_count;
  logic [1:0]  c_fifo_ovf;

  int checks = 0;
  int errors = 0;
  int main_n = 0;
  int cap_n = 0;
  int c_pulses = 0;
  bit cap_on = 1'b0;
  logic [31:0] q[$];
  logic [31:0] cq[$];
  logic [31:0] m_exp, c_exp;

  keypoint_write_arbiter #(.FIFO_DEPTH(2), .MAX_KP(4096), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_done(src_done),
    .kp1_we(kp1_we), .kp1_din(kp1_din), .kp2_we(kp2_we), .kp2_din(kp2_din),
    .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din),
    .kp1_count(kp1_count), .kp2_count(kp2_count), .total_count(total_count),
    .fifo_ovf(fifo_ovf), .mem_full(mem_full), .done(done)
  );

  keypoint_write_arbiter #(.FIFO_DEPTH(4), .MAX_KP(8), .ADDR_W(3)) dut_cap (
    .clk(clk), .rst_n(rst_n), .start(c_start), .src_done(src_done),
    .kp1_we(kp1_we), .kp1_din(kp1_din), .kp2_we(kp2_we), .kp2_din(kp2_din),
    .kp_we(c_kp_we), .kp_addr(c_kp_addr), .kp_din(c_kp_din),
    .kp1_count(c_kp1_count), .kp2_count(c_kp2_count), .total_count(c_total_count),
    .fifo_ovf(c_fifo_ovf), .mem_full(c_mem_full), .done(c_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kp_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL main_write unexpected: addr=%0d din=%05h", kp_addr, kp_din);
      end else begin
        m_exp = q.pop_front();
        if ({kp_addr, kp_din} !== m_exp) begin
          errors++;
          $display("FAIL main_write got addr=%0d din=%05h expected addr=%0d din=%05h",
                   kp_addr, kp_din, m_exp[31:20], m_exp[19:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (c_kp_we) begin
      checks++;
      c_pulses++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL cap_write unexpected: addr=%0d din=%05h", c_kp_addr, c_kp_din);
      end else begin
        c_exp = cq.pop_front();
        if ({9'b0, c_kp_addr, c_kp_din} !== c_exp) begin
          errors++;
          $display("FAIL cap_write got addr=%0d din=%05h expected addr=%0d din=%05h",
                   c_kp_addr, c_kp_din, c_exp[31:20], c_exp[19:0]);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] kw(input int r, input int c);
    return {9'(r), 10'(c)};
  endfunction

  task automatic exp_wr(input logic s, input logic [18:0] w);
    q.push_back({12'(main_n), s, w});
    main_n++;
    if (cap_on && cap_n < 8) begin
      cq.push_back({12'(cap_n), s, w});
      cap_n++;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic do_start(input bit with_cap);
    start   = 1'b1;
    c_start = with_cap;
    main_n  = 0;
    cap_on  = with_cap;
    if (with_cap) begin
      cap_n    = 0;
      c_pulses = 0;
    end
    cyc(1);
    start   = 1'b0;
    c_start = 1'b0;
  endtask

  task automatic finish_frame(input string name);
    int n;
    src_done = 1'b1;
    cyc(1);
    src_done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      cyc(1);
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_all_written"}, 32'(q.size()), 32'd0);
  endtask

  int ord_s[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int ord_i[10] = '{1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

  initial begin
    cyc(2);
    chk("rst_kp_we", 32'(kp_we), 0);
    chk("rst_kp_addr", 32'(kp_addr), 0);
    chk("rst_total", 32'(total_count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", {29'b0, fifo_ovf, mem_full}, 0);
    rst_n = 1'b1;
    cyc(1);

    // single push, latency two cycles
    do_start(0);
    exp_wr(1'b0, kw(5, 100));
    kp1_din = kw(5, 100);
    kp1_we  = 1'b1;
    cyc(1);
    kp1_we = 1'b0;
    chk("t1_lat_n1", 32'(kp_we), 0);
    cyc(1);
    chk("t1_lat_n2", 32'(kp_we), 1);
    chk("t1_addr", 32'(kp_addr), 0);
    chk("t1_din", 32'(kp_din), 32'h01464);
    chk("t1_kp1_count", 32'(kp1_count), 1);
    finish_frame("t1");
    chk("t1_total", 32'(total_count), 1);

    // alternate-cycle bursts on both streams, plus an ignored start in ST_RUN
    do_reset();
    do_start(0);
    exp_wr(1'b0, kw(1, 11));
    exp_wr(1'b1, kw(1, 21));
    exp_wr(1'b0, kw(2, 12));
    exp_wr(1'b1, kw(2, 22));
    kp1_din = kw(1, 11); kp2_din = kw(1, 21); kp1_we = 1'b1; kp2_we = 1'b1;
    cyc(1);
    kp1_we = 1'b0; kp2_we = 1'b0;
    cyc(1);
    kp1_din = kw(2, 12); kp2_din = kw(2, 22); kp1_we = 1'b1; kp2_we = 1'b1;
    cyc(1);
    kp1_we = 1'b0; kp2_we = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    finish_frame("t2");
    chk("t2_kp1_count", 32'(kp1_count), 2);
    chk("t2_kp2_count", 32'(kp2_count), 2);
    chk("t2_total", 32'(total_count), 4);
    chk("t2_ovf", 32'(fifo_ovf), 0);

    // overflow: both streams saturated for 7 cycles into 2-deep FIFOs
    do_reset();
    do_start(0);
    for (int k = 0; k < 10; k++)
      exp_wr(1'(ord_s[k]), (ord_s[k] != 0) ? kw(ord_i[k], 200 + ord_i[k]) : kw(ord_i[k], 100 + ord_i[k]));
    for (int i = 1; i <= 7; i++) begin
      kp1_din = kw(i, 100 + i); kp2_din = kw(i, 200 + i); kp1_we = 1'b1; kp2_we = 1'b1;
      cyc(1);
    end
    kp1_we = 1'b0; kp2_we = 1'b0;
    finish_frame("t3");
    chk("t3_ovf", 32'(fifo_ovf), 32'b11);
    chk("t3_kp1_count", 32'(kp1_count), 5);
    chk("t3_kp2_count", 32'(kp2_count), 5);
    chk("t3_total", 32'(total_count), 10);

    // drain: src_done with the last push; pushes in DRAIN and DONE ignored
    do_start(0);
    chk("t4_clr_ovf", 32'(fifo_ovf), 0);
    chk("t4_clr_count", 32'(total_count), 0);
    for (int i = 1; i <= 3; i++) exp_wr(1'b1, kw(40 + i, 300 + i));
    for (int i = 1; i <= 3; i++) begin
      kp2_din = kw(40 + i, 300 + i); kp2_we = 1'b1; src_done = (i == 3);
      cyc(1);
    end
    src_done = 1'b0; kp2_din = kw(99, 99);
    cyc(1);
    kp2_we = 1'b0;
    finish_frame("t4");
    chk("t4_kp2_count", 32'(kp2_count), 3);
    chk("t4_total", 32'(total_count), 3);
    kp1_din = kw(77, 77); kp1_we = 1'b1;
    cyc(3);
    kp1_we = 1'b0;
    cyc(3);
    chk("t4_done_ignores_we", 32'(kp1_count), 0);
    chk("t4_done_held", 32'(done), 1);

    // capacity: 10 words into the MAX_KP=8 instance
    do_start(1);
    for (int i = 0; i < 10; i++) exp_wr(1'b0, kw(60 + i, 400 + i));
    for (int i = 0; i < 10; i++) begin
      kp1_din = kw(60 + i, 400 + i); kp1_we = 1'b1; src_done = (i == 9);
      cyc(1);
    end
    kp1_we = 1'b0; src_done = 1'b0;
    for (int n = 0; n < 200 && !(done && c_done); n++) cyc(1);
    chk("t5_main_done", 32'(done), 1);
    chk("t5_cap_done", 32'(c_done), 1);
    chk("t5_main_total", 32'(total_count), 10);
    chk("t5_main_mem_full", 32'(mem_full), 0);
    chk("t5_cap_pulses", 32'(c_pulses), 8);
    chk("t5_cap_total", 32'(c_total_count), 8);
    chk("t5_cap_addr", 32'(c_kp_addr), 7);
    chk("t5_cap_mem_full", 32'(c_mem_full), 1);
    chk("t5_cap_queue", 32'(cq.size()), 0);
    cap_on = 1'b0;

    // asynchronous reset between clock edges mid-frame
    do_start(0);
    exp_wr(1'b0, kw(3, 33));
    kp1_din = kw(3, 33); kp1_we = 1'b1;
    cyc(1);
    kp1_din = kw(4, 44);
    cyc(1);
    kp1_we = 1'b0;
    cyc(1);
    chk("t6_pre_we", 32'(kp_we), 1);
    chk("t6_pre_addr", 32'(kp_addr), 1);
    chk("t6_pre_count", 32'(kp1_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(kp_we), 0);
    chk("t6_rst_addr", 32'(kp_addr), 0);
    chk("t6_rst_counts", {kp1_count, kp2_count, 6'b0}, 0);
    chk("t6_rst_flags", {29'b0, fifo_ovf, done}, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    do_start(0);
    exp_wr(1'b1, kw(9, 9));
    kp2_din = kw(9, 9); kp2_we = 1'b1;
    cyc(1);
    kp2_we = 1'b0;
    cyc(2);
    finish_frame("t6");
    chk("t6_kp2_count", 32'(kp2_count), 1);
    chk("t6_kp1_count", 32'(kp1_count), 0);

    cyc(2);
    chk("end_main_queue", 32'(q.size()), 0);
    chk("end_cap_queue", 32'(cq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
